// File: rtl/div_result_display_pkg.sv
// Shared types, segment codes and the double-dabble step for div_result_display.
`default_nettype none

package divdisp_pkg;

  localparam int BCD_W = 12;
  localparam int BIN_W = 7;
  localparam int SR_W  = BCD_W + BIN_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_Q = 2'd1,
    CONV_R = 2'd2
  } divdisp_state_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d <= 4'd9) return SEG_DIGIT[d];
    return SEG_BLANK;
  endfunction

  // One shift-add-3 iteration over {bcd[11:0], bin[6:0]}.
  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
    logic [SR_W-1:0] t;
    t = s;
    for (int n = 0; n < 3; n++) begin
      if (t[BIN_W + 4*n +: 4] >= 4'd5)
        t[BIN_W + 4*n +: 4] = t[BIN_W + 4*n +: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_result_display_seg7_scan.sv
// Multiplexed 4-digit seven-segment scanner: scan counter, digit index, anode and segment registers.
`default_nettype none

module seg7_scan
  import divdisp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       tag_r,
  input  logic       shown,
  input  logic [1:0] blank,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       digit;
  logic [1:0]       next_digit;
  logic [6:0]       next_seg;

  assign next_digit = digit + 2'd1;

  // Segment pattern for the digit about to become active; blank[1] masks hundreds, blank[0] tens.
  always_comb begin
    next_seg = SEG_DASH;
    if (shown) begin
      case (next_digit)
        2'd0:    next_seg = seg_of(units);
        2'd1:    next_seg = blank[0] ? SEG_BLANK : seg_of(tens);
        2'd2:    next_seg = blank[1] ? SEG_BLANK : seg_of(hundreds);
        default: next_seg = tag_r ? SEG_R : SEG_Q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
      an       <= 4'b1110;
      seg      <= SEG_DASH;
    end else if (scan_cnt == CNT_MAX) begin
      scan_cnt <= '0;
      digit    <= next_digit;
      an       <= ~(4'b0001 << next_digit);
      seg      <= next_seg;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/div_result_display.sv
// Captures divider Q/R, converts both to BCD by double-dabble and drives a scanned 7-seg display.
// Optional leading-zero blanking: define DIVDISP_ZERO_BLANK_EN.
`default_nettype none

module div_result_display
  import divdisp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done_in,
  input  logic [BIN_W-1:0] q_in,
  input  logic [BIN_W-1:0] r_in,
  input  logic             sel_r,
  output logic [BCD_W-1:0] bcd_q,
  output logic [BCD_W-1:0] bcd_r,
  output logic             bcd_valid,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  divdisp_state_t   state;
  logic             done_d;
  logic             start_cv;
  logic [BIN_W-1:0] r_lat;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_next;
  logic [2:0]       bit_cnt;
  logic [BCD_W-1:0] q_tmp;
  logic             shown;
  logic [BCD_W-1:0] disp_val;
  logic [1:0]       blank;

  assign start_cv = done_in & ~done_d;
  assign sr_next  = dd_step(sr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      done_d    <= 1'b0;
      r_lat     <= '0;
      sr        <= '0;
      bit_cnt   <= 3'd0;
      q_tmp     <= '0;
      bcd_q     <= '0;
      bcd_r     <= '0;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
      shown     <= 1'b0;
    end else begin
      done_d <= done_in;
      case (state)
        IDLE: begin
          if (start_cv) begin
            r_lat     <= r_in;
            sr        <= {{BCD_W{1'b0}}, q_in};
            bit_cnt   <= 3'd7;
            busy      <= 1'b1;
            bcd_valid <= 1'b0;
            state     <= CONV_Q;
          end
        end
        CONV_Q: begin
          if (bit_cnt == 3'd1) begin
            q_tmp   <= sr_next[SR_W-1:BIN_W];
            sr      <= {{BCD_W{1'b0}}, r_lat};
            bit_cnt <= 3'd7;
            state   <= CONV_R;
          end else begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        CONV_R: begin
          // Extra settle edge after the 7th shift publishes both results together.
          if (bit_cnt != 3'd0) begin
            sr      <= sr_next;
            bit_cnt <= bit_cnt - 3'd1;
          end else begin
            bcd_q     <= q_tmp;
            bcd_r     <= sr[SR_W-1:BIN_W];
            bcd_valid <= 1'b1;
            busy      <= 1'b0;
            shown     <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign disp_val = sel_r ? bcd_r : bcd_q;

`ifdef DIVDISP_ZERO_BLANK_EN
  assign blank = {disp_val[11:8] == 4'd0, (disp_val[11:8] == 4'd0) && (disp_val[7:4] == 4'd0)};
`else
  assign blank = 2'b00;
`endif

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .units    (disp_val[3:0]),
    .tens     (disp_val[7:4]),
    .hundreds (disp_val[11:8]),
    .tag_r    (sel_r),
    .shown    (shown),
    .blank    (blank),
    .an       (an),
    .seg      (seg)
  );

endmodule

`default_nettype wire

// File: tb/tb_div_result_display.sv
// Randomised and directed bench for div_result_display against an arithmetic reference model.
`default_nettype none

module tb_div_result_display;

  localparam int S = 4;
`ifdef DIVDISP_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] BLNK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done_in = 1'b0;
  logic        sel_r = 1'b0;
  logic [6:0]  q_in = '0;
  logic [6:0]  r_in = '0;
  logic [11:0] bcd_q, bcd_r;
  logic        bcd_valid, busy;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad   = 0;

  div_result_display #(.SCAN_DIV(S)) dut (
    .clk(clk), .rst(rst), .done_in(done_in), .q_in(q_in), .r_in(r_in), .sel_r(sel_r),
    .bcd_q(bcd_q), .bcd_r(bcd_r), .bcd_valid(bcd_valid), .busy(busy), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLNK;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int idx, input bit sh, input logic [11:0] bq,
                                         input logic [11:0] br, input bit sel);
    int h, t, u;
    logic [11:0] v;
    if (!sh) return DASH;
    v = sel ? br : bq;
    h = int'(v[11:8]);
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    case (idx)
      3: return sel ? 7'b0101111 : 7'b0011000;
      2: return (ZB && h == 0) ? BLNK : digit_code(h);
      1: return (ZB && h == 0 && t == 0) ? BLNK : digit_code(t);
      default: return digit_code(u);
    endcase
  endfunction

  // Reference model: a conversion accepted at edge k publishes at edge k+15.
  logic [11:0] m_bq = '0, m_br = '0;
  bit          m_valid = 0, m_busy = 0, m_shown = 0, m_done_d = 0, m_live = 0, m_start;
  int          m_left = 0, m_lq = 0, m_lr = 0, m_j = 0, m_idx = 0;
  logic [3:0]  m_an = 4'b1110;
  logic [6:0]  m_seg = DASH;

  always @(posedge clk) begin
    if (!rst) begin
      m_bq = '0; m_br = '0; m_valid = 0; m_busy = 0; m_shown = 0; m_done_d = 0;
      m_left = 0; m_j = 0; m_idx = 0; m_an = 4'b1110; m_seg = DASH; m_live = 1;
    end else begin
      m_j++;
      if (m_j % S == 0) begin
        m_idx = (m_idx + 1) % 4;
        m_an  = ~(4'b0001 << m_idx);
        m_seg = exp_seg(m_idx, m_shown, m_bq, m_br, sel_r);
      end
      m_start  = done_in && !m_done_d;
      m_done_d = done_in;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_bq = to_bcd(m_lq); m_br = to_bcd(m_lr);
          m_valid = 1; m_busy = 0; m_shown = 1;
        end
      end else if (m_start) begin
        m_lq = int'(q_in); m_lr = int'(r_in);
        m_busy = 1; m_valid = 0; m_left = 15;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_live) begin
      check("bcd_q", bcd_q, m_bq);
      check("bcd_r", bcd_r, m_br);
      check("bcd_valid", bcd_valid, m_valid);
      check("busy", busy, m_busy);
      check("an", an, m_an);
      check("seg", seg, m_seg);
    end
  end

  task automatic run_conv(input int q, input int r, input logic [11:0] eq, input logic [11:0] er);
    @(negedge clk); done_in = 1'b1; q_in = 7'(q); r_in = 7'(r);
    @(negedge clk); done_in = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("lit_busy_k14", busy, 1'b1);
    check("lit_valid_k14", bcd_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lit_valid_k15", bcd_valid, 1'b1);
    check("lit_busy_k15", busy, 1'b0);
    check("lit_bcd_q", bcd_q, eq);
    check("lit_bcd_r", bcd_r, er);
    @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (an !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (an !== target) check("wait_an_timeout", an, target);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("lit_reset_an", an, 4'b1110);
    check("lit_reset_seg", seg, DASH);
    check("lit_reset_valid", bcd_valid, 1'b0);
    check("lit_reset_bcdq", bcd_q, 12'h000);

    run_conv(3, 1, 12'h003, 12'h001);
    run_conv(127, 0, 12'h127, 12'h000);
    run_conv(14, 5, 12'h014, 12'h005);

    // Level-held done_in with operands changing mid-way: one conversion only.
    @(negedge clk); done_in = 1'b1; q_in = 7'd20; r_in = 7'd9;
    repeat (8) @(negedge clk);
    q_in = 7'd99; r_in = 7'd3;
    repeat (12) @(negedge clk);
    done_in = 1'b0;
    repeat (2) @(negedge clk);
    check("lit_hold_bcdq", bcd_q, 12'h020);
    check("lit_hold_bcdr", bcd_r, 12'h009);
    check("lit_hold_busy", busy, 1'b0);

    // Scan sequence for Q=50, then R tag.
    run_conv(50, 0, 12'h050, 12'h000);
    sel_r = 1'b0;
    wait_an(4'b0111);
    wait_an(4'b1110);
    check("lit_scan_d0", seg, 7'b1000000);
    repeat (4) @(negedge clk);
    check("lit_scan_an1", an, 4'b1101);
    check("lit_scan_d1", seg, 7'b0010010);
    repeat (4) @(negedge clk);
    check("lit_scan_an2", an, 4'b1011);
    check("lit_scan_d2", seg, ZB ? BLNK : 7'b1000000);
    repeat (4) @(negedge clk);
    check("lit_scan_an3", an, 4'b0111);
    check("lit_scan_d3", seg, 7'b0011000);
    sel_r = 1'b1;
    wait_an(4'b1011);
    wait_an(4'b0111);
    check("lit_tag_r", seg, 7'b0101111);
    wait_an(4'b1110);
    check("lit_r_units", seg, 7'b1000000);
    sel_r = 1'b0;

    // Leading-zero handling for Q=7.
    run_conv(7, 2, 12'h007, 12'h002);
    wait_an(4'b0111);
    wait_an(4'b1110);
    check("lit_q7_d0", seg, 7'b1111000);
    repeat (4) @(negedge clk);
    check("lit_q7_d1", seg, ZB ? BLNK : 7'b1000000);
    repeat (4) @(negedge clk);
    check("lit_q7_d2", seg, ZB ? BLNK : 7'b1000000);

    // Random traffic, including edges while busy.
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) done_in = ~done_in;
      if ($urandom_range(0, 2) == 0) q_in = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) r_in = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) sel_r = ~sel_r;
    end
    done_in = 1'b0;
    repeat (20) @(negedge clk);

    // Reset asserted at edge k+6 of a conversion.
    @(negedge clk); done_in = 1'b1; q_in = 7'd88; r_in = 7'd11;
    @(negedge clk); done_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("lit_rst_busy", busy, 1'b0);
    check("lit_rst_valid", bcd_valid, 1'b0);
    check("lit_rst_bcdq", bcd_q, 12'h000);
    check("lit_rst_seg", seg, DASH);
    check("lit_rst_an", an, 4'b1110);
    @(negedge clk); rst = 1'b1;
    repeat (4 * S + 2) @(negedge clk);
    check("lit_post_rst_dash", seg, DASH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
